// File: rtl/cp0_pkg.sv
// cp0_pkg: shared CP0 register numbers, exception codes and field positions
package cp0_pkg;
    localparam logic [4:0] CP0_SR = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC = 5'd14;
    localparam logic [4:0] CP0_PRID = 5'd15;
    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI = 5'd10;
    localparam logic [4:0] EXC_OV = 5'd12;
    localparam int IM_HI = 15;
    localparam int IM_LO = 10;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT = 0;
    localparam int BD_BIT = 31;
    localparam int IP_HI = 15;
    localparam int IP_LO = 10;
    localparam int EXC_HI = 6;
    localparam int EXC_LO = 2;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
endpackage

// File: rtl/cp0_req_gen.sv
// cp0_req_gen: decides whether the M-stage slot traps and which ExcCode it records
module cp0_req_gen
    import cp0_pkg::*;
(
    input  logic [5:0] i_hw_int,
    input  logic [5:0] i_im,
    input  logic       i_ie,
    input  logic       i_exl,
    input  logic [4:0] i_exc_code,
    output logic       o_req,
    output logic [4:0] o_exc_code
);
    logic w_int_req;
    logic w_exc_req;
    assign w_int_req = |(i_hw_int & i_im) & i_ie & ~i_exl;
    assign w_exc_req = (i_exc_code != 5'd0) & ~i_exl;
    assign o_req = w_int_req | w_exc_req;
    assign o_exc_code = w_int_req ? EXC_INT : i_exc_code;
endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: M-stage coprocessor 0 holding SR/Cause/EPC/PRId and raising the flush request
module cp0_unit #(
    parameter logic [31:0] PRID_VALUE = 32'h2023_0701,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_en,
    input  logic [4:0]  i_cp0_addr,
    input  logic [31:0] i_cp0_wdata,
    input  logic [31:0] i_vpc,
    input  logic        i_bd_in,
    input  logic [4:0]  i_exc_code_in,
    input  logic [5:0]  i_hw_int,
    input  logic        i_eret,
    output logic [31:0] o_cp0_rdata,
    output logic [31:0] o_epc_out,
    output logic        o_req,
    output logic [31:0] o_handler_pc
);
    import cp0_pkg::*;
    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exc;
    logic [31:0] r_epc;
    logic        w_req;
    logic [4:0]  w_code;
    logic [31:0] w_sr;
    logic [31:0] w_cause;
    cp0_req_gen u_req_gen (
        .i_hw_int  (i_hw_int),
        .i_im      (r_im),
        .i_ie      (r_ie),
        .i_exl     (r_exl),
        .i_exc_code(i_exc_code_in),
        .o_req     (w_req),
        .o_exc_code(w_code)
    );
    // A trap drops any same-cycle mtc0/eret; otherwise an eret's EXL clear beats an SR write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_im <= '0;
            r_exl <= 1'b0;
            r_ie <= 1'b0;
            r_bd <= 1'b0;
            r_ip <= '0;
            r_exc <= '0;
            r_epc <= '0;
        end else begin
            r_ip <= i_hw_int;
            if (w_req) begin
                r_exl <= 1'b1;
                r_exc <= w_code;
                r_bd <= i_bd_in;
                r_epc <= i_bd_in ? i_vpc - 32'd4 : i_vpc;
            end else begin
                if (i_en && i_cp0_addr == CP0_SR) begin
                    r_im <= i_cp0_wdata[IM_HI:IM_LO];
                    r_exl <= i_cp0_wdata[EXL_BIT];
                    r_ie <= i_cp0_wdata[IE_BIT];
                end
                if (i_en && i_cp0_addr == CP0_EPC) r_epc <= i_cp0_wdata;
                if (i_eret) r_exl <= 1'b0;
            end
        end
    end
    assign w_sr = {16'b0, r_im, 8'b0, r_exl, r_ie};
    assign w_cause = {r_bd, 15'b0, r_ip, 3'b0, r_exc, 2'b0};
    assign o_cp0_rdata = i_cp0_addr == CP0_SR ? w_sr :
                         i_cp0_addr == CP0_CAUSE ? w_cause :
                         i_cp0_addr == CP0_EPC ? r_epc :
                         i_cp0_addr == CP0_PRID ? PRID_VALUE : 32'd0;
    assign o_epc_out = r_epc;
    assign o_req = w_req;
    assign o_handler_pc = HANDLER_PC;
endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed vectors with hand-computed expectations for cp0_unit
module tb_cp0_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        eret;
    logic [31:0] cp0_rdata;
    logic [31:0] epc_out;
    logic        req;
    logic [31:0] handler_pc;
    int total = 0;
    int bad = 0;
    cp0_unit dut (
        .clk          (clk),
        .reset        (reset),
        .i_en         (en),
        .i_cp0_addr   (cp0_addr),
        .i_cp0_wdata  (cp0_wdata),
        .i_vpc        (vpc),
        .i_bd_in      (bd_in),
        .i_exc_code_in(exc_code_in),
        .i_hw_int     (hw_int),
        .i_eret       (eret),
        .o_cp0_rdata  (cp0_rdata),
        .o_epc_out    (epc_out),
        .o_req        (req),
        .o_handler_pc (handler_pc)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        cp0_addr = a;
        #1;
        chk(tag, cp0_rdata, exp);
    endtask
    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        en = 1'b1;
        cp0_addr = a;
        cp0_wdata = d;
        tick();
        en = 1'b0;
    endtask
    initial begin
        reset = 1'b1;
        en = 1'b0;
        cp0_addr = '0;
        cp0_wdata = '0;
        vpc = '0;
        bd_in = 1'b0;
        exc_code_in = '0;
        hw_int = '0;
        eret = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        rd("rst_sr", 5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_epc", 5'd14, 32'h0);
        rd("rst_prid", 5'd15, 32'h2023_0701);
        rd("unmapped", 5'd3, 32'h0);
        chk("rst_req", {31'b0, req}, 32'h0);
        chk("rst_epc_out", epc_out, 32'h0);
        chk("handler_pc", handler_pc, 32'h0000_4180);
        mtc0(5'd12, 32'h0000_FC01);
        rd("sr_written", 5'd12, 32'h0000_FC01);
        hw_int = 6'b000100;
        vpc = 32'h3010;
        #1;
        chk("int_req", {31'b0, req}, 32'h1);
        tick();
        rd("int_cause", 5'd13, 32'h0000_1000);
        rd("int_epc", 5'd14, 32'h3010);
        rd("int_sr", 5'd12, 32'h0000_FC03);
        chk("int_exl_blocks", {31'b0, req}, 32'h0);
        hw_int = '0;
        mtc0(5'd12, 32'h0);
        exc_code_in = 5'd12;
        vpc = 32'h3024;
        bd_in = 1'b1;
        #1;
        chk("ov_req", {31'b0, req}, 32'h1);
        tick();
        exc_code_in = '0;
        bd_in = 1'b0;
        rd("ov_cause", 5'd13, 32'h8000_0030);
        rd("ov_epc", 5'd14, 32'h3020);
        mtc0(5'd12, 32'h0000_0401);
        rd("sr_0401", 5'd12, 32'h0000_0401);
        hw_int = 6'b000001;
        exc_code_in = 5'd8;
        vpc = 32'h3100;
        en = 1'b1;
        cp0_addr = 5'd14;
        cp0_wdata = 32'hDEAD;
        #1;
        chk("sim_req", {31'b0, req}, 32'h1);
        tick();
        en = 1'b0;
        exc_code_in = '0;
        rd("sim_cause", 5'd13, 32'h0000_0400);
        rd("sim_epc", 5'd14, 32'h3100);
        rd("sim_sr", 5'd12, 32'h0000_0403);
        hw_int = '0;
        exc_code_in = 5'd10;
        vpc = 32'h3200;
        #1;
        chk("nest_req", {31'b0, req}, 32'h0);
        tick();
        exc_code_in = '0;
        rd("nest_epc", 5'd14, 32'h3100);
        eret = 1'b1;
        #1;
        chk("eret_epc_out", epc_out, 32'h3100);
        chk("eret_req", {31'b0, req}, 32'h0);
        tick();
        eret = 1'b0;
        rd("eret_sr", 5'd12, 32'h0000_0401);
        exc_code_in = 5'd4;
        vpc = 32'h3300;
        reset = 1'b1;
        #1;
        chk("pre_rst_req", {31'b0, req}, 32'h1);
        tick();
        reset = 1'b0;
        rd("mid_rst_sr", 5'd12, 32'h0);
        rd("mid_rst_cause", 5'd13, 32'h0);
        rd("mid_rst_epc", 5'd14, 32'h0);
        chk("mid_rst_epc_out", epc_out, 32'h0);
        chk("mid_rst_req", {31'b0, req}, 32'h1);
        exc_code_in = '0;
        #1;
        chk("idle_req", {31'b0, req}, 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor 0 for the five-stage MIPS pipeline, placed in the M stage directly upstream of the M/W pipeline register. It holds the SR, Cause, EPC and PRId registers and serves `mfc0`/`mtc0` accesses. It decides each cycle whether the M-stage instruction takes an exception or interrupt, then drives `req`. `req` flushes every pipeline register, and the M/W register loads PC 0x0000_4180. `cp0_rdata` feeds the W-stage `mfc0` write-back path.

## Interface
- `PRID_VALUE`, default 32'h2023_0701, read-only contents of PRId.
- `HANDLER_PC`, default 32'h0000_4180, exception entry address, exported for the PC mux.
- `clk  in  1  clock`
- `reset  in  1  reset, synchronous, active-high`
- `en  in  1  mtc0 write strobe from M stage`
- `cp0_addr  in  5  register number for mfc0/mtc0`
- `cp0_wdata  in  32  mtc0 data (forwarded rt value)`
- `vpc  in  32  PC of the current M-stage instruction (or bubble's PC)`
- `bd_in  in  1  M-stage instruction is in a branch delay slot`
- `exc_code_in  in  5  accumulated exception code, 0 = none`
- `hw_int  in  6  external interrupt lines [5:0]`
- `eret  in  1  M-stage instruction is eret`
- `cp0_rdata  out  32  combinational read of `cp0_addr``
- `epc_out  out  32  current EPC, used by F stage on eret`
- `req  out  1  take exception/interrupt this cycle`

## Operation
- SR (12): IM=[15:10], EXL=[1], IE=[0]; all other bits read 0.
- Cause (13): BD=[31], IP=[15:10], ExcCode=[6:2]; all other bits read 0. Software cannot write Cause.
- EPC (14): 32-bit, read/write.
- PRId (15): constant `PRID_VALUE`.
- Unmapped addresses read 0, and writes to them are ignored.
- Interrupt pending: `int_req = |(hw_int & IM) & IE & !EXL`.
- Exception pending: `exc_req = (exc_code_in != 0) & !EXL`.
- `req = int_req | exc_req`. An interrupt has priority over an exception in the same cycle.
- Actions on `req` at posedge:
  - EXL is set to 1.
  - ExcCode is set to 0 if `int_req`, otherwise to `exc_code_in`.
  - BD is set to `bd_in`.
  - EPC is set to `bd_in ? vpc-4 : vpc`, computed mod 2^32.
- `req` overrides `en` and `eret` in the same cycle: the mtc0 write is dropped and EXL stays 1.
- `eret` without `req`: EXL is cleared at the next posedge. `epc_out` is valid combinationally during the eret cycle.
- `en` without `req`:
  - Address 12 writes IM, EXL and IE from the matching bits of `cp0_wdata`.
  - Address 14 writes EPC in full.
  - Other addresses are ignored.
- `en` and `eret` in the same cycle cannot be produced by decode. If it occurs, the write applies first and the EXL clear wins.
- IP is loaded from `hw_int` at every posedge, regardless of EXL and `req`.

## Timing
- Reset: SR, Cause and EPC all read 0. After reset `req`=0 until an exception or enabled interrupt arrives; `epc_out`=0.
- Reset during a pending `req` discards the exception: registers go to 0.
- `req`, `cp0_rdata` and `epc_out` are combinational, with zero latency from inputs and state.
- All register updates land at the posedge following the request cycle. An mfc0 in the next cycle sees the new value.
- A bubble carrying an interrupt is legal: an interrupt with `vpc` of a flushed slot uses that slot's PC, and `bd_in` is propagated by the pipeline.
- With EXL=1, neither interrupts nor exceptions raise `req`, and EPC holds its value.

## Structure
- Shared package `cp0_pkg` holds:
  - register numbers `CP0_SR=12`, `CP0_CAUSE=13`, `CP0_EPC=14`, `CP0_PRID=15`;
  - ExcCode constants `EXC_INT=0`, `EXC_ADEL=4`, `EXC_ADES=5`, `EXC_SYSCALL=8`, `EXC_RI=10`, `EXC_OV=12`;
  - bit-position constants for IM, EXL, IE, BD, IP and ExcCode;
  - `HANDLER_PC`.
- One combinational sub-module `cp0_req_gen` computes `int_req`, `exc_req`, `req` and the selected ExcCode. Register state stays in `cp0_unit`.

## Test plan
- **Reset, then reads.** Apply reset, then mfc0 of 12/13/14/15 → 0, 0, 0, `PRID_VALUE`; `req`=0.
- **Interrupt.** mtc0 SR=32'h0000_FC01, then `hw_int`=6'b000100 with `vpc`=0x3010 and `bd_in`=0. `req`=1 that cycle. Next cycle: Cause=32'h0000_1000, EPC=0x3010, SR=32'h0000_FC03.
- **Exception in a delay slot.** With IE=0, apply `exc_code_in`=12 (Ov), `vpc`=0x3024, `bd_in`=1. Response: `req`=1; then Cause=32'h8000_0030 and EPC=0x3020.
- **Simultaneous events.** With SR=32'h0000_0401, drive `hw_int`[0]=1, `exc_code_in`=8 and `en`=1 to EPC=0xDEAD together. Response: ExcCode=0 and EPC=`vpc`; the mtc0 is dropped.
- **Nesting blocked, then eret.** With EXL=1, apply `exc_code_in`=10 → `req`=0 and EPC unchanged. Then `eret` → `epc_out`=EPC that cycle, and EXL=0 next cycle.
- **Reset mid-operation.** Assert `reset` in the same cycle as `exc_code_in`=4. Next cycle all registers read 0, and `req` follows the new state.
